// File: rtl/noc_mem_pkg.sv
// Shared opcodes, packet offsets, FSM states and request-entry type for the NoC-to-memory bridge.
package noc_mem_pkg;

  localparam logic [7:0] OP_READ      = 8'h01;
  localparam logic [7:0] OP_WRITE     = 8'h02;
  localparam logic [7:0] OP_READ_ACK  = 8'h81;
  localparam logic [7:0] OP_WRITE_ACK = 8'h82;
  localparam logic [7:0] OP_ERR       = 8'hFF;

  localparam int OFS_OP     = 0;
  localparam int OFS_ADDR   = 1;
  localparam int OFS_DATA   = 5;
  localparam int ADDR_BYTES = 4;
  localparam int DATA_BYTES = 16;

  localparam logic [5:0] BP_SHORT = 6'd5;
  localparam logic [5:0] BP_LONG  = 6'd21;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic [7:0]   op;
    logic [31:0]  addr;
    logic [127:0] data;
    logic [5:0]   bp;
  } req_t;

  function automatic logic req_legal(req_t r);
    return ((r.op == OP_READ)  && (r.bp == BP_SHORT)) ||
           ((r.op == OP_WRITE) && (r.bp == BP_LONG));
  endfunction

endpackage

// File: rtl/noc_mem_req_fifo.sv
// Synchronous request FIFO; a push while full is only taken when a pop frees a slot the same edge.
module noc_mem_req_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [7:0]
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t wdata,
  input  logic   pop,
  output entry_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (!do_push && do_pop) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/noc_mem_interface.sv
// NoC request/response bridge to a 128-bit line memory on a shared tri-state bus.
// Define ERR_RESP_EN to answer illegal requests with an 0xFF error packet instead of discarding them.
//
// state     | meaning
// ST_IDLE   | waiting for a queued request; pops the FIFO head
// ST_ACCESS | mem_en held for MEM_LAT cycles; read data captured on the last edge
// ST_RESP   | one-cycle response strobe on the NoC output
module noc_mem_interface
  import noc_mem_pkg::*;
#(
  parameter int REQ_FIFO_DEPTH = 4,
  parameter int MEM_LAT        = 2
) (
  input  logic             fclk,
  input  logic             rst,
  input  logic [31:0][7:0] noc_inp_dat,
  input  logic [5:0]       noc_inp_bp,
  input  logic             noc_inp_bo,
  output logic [31:0][7:0] noc_oup_dat,
  output logic [5:0]       noc_oup_bp,
  output logic             noc_oup_bo,
  output logic             mem_en,
  output logic             mem_we,
  output logic             mem_re,
  output logic [31:0]      mem_addr_sel,
  inout  wire  [127:0]     mem_dat
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t        state;
  state_t        state_n;
  req_t          req_in;
  req_t          head;
  req_t          cur;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] cnt;
  logic [127:0]  rd_data;
  logic          unused_bytes;

  assign unused_bytes = ^noc_inp_dat[31:21];

  always_comb begin
    req_in    = '0;
    req_in.op = noc_inp_dat[OFS_OP];
    for (int i = 0; i < ADDR_BYTES; i++) req_in.addr[8*i +: 8] = noc_inp_dat[OFS_ADDR + i];
    for (int i = 0; i < DATA_BYTES; i++) req_in.data[8*i +: 8] = noc_inp_dat[OFS_DATA + i];
    req_in.bp = noc_inp_bp;
  end

  assign push = noc_inp_bo && rst && (!fifo_full || pop);

  noc_mem_req_fifo #(
    .DEPTH   (REQ_FIFO_DEPTH),
    .entry_t (req_t)
  ) u_req_fifo (
    .clk   (fclk),
    .rst   (rst),
    .push  (push),
    .wdata (req_in),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (req_legal(head)) state_n = ST_ACCESS;
`ifdef ERR_RESP_EN
          else state_n = ST_RESP;
`else
          else state_n = ST_IDLE;
`endif
        end
      end
      ST_ACCESS: if (cnt == '0) state_n = ST_RESP;
      ST_RESP:   state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge fclk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cur     <= '0;
      cnt     <= '0;
      rd_data <= '0;
    end else begin
      state <= state_n;
      if (pop) cur <= head;
      if (state == ST_IDLE) cnt <= CW'(MEM_LAT - 1);
      else if (state == ST_ACCESS && cnt != '0) cnt <= cnt - 1'b1;
      if (state == ST_ACCESS && cnt == '0 && cur.op == OP_READ) rd_data <= mem_dat;
    end
  end

  assign mem_en       = (state == ST_ACCESS);
  assign mem_we       = mem_en && (cur.op == OP_WRITE);
  assign mem_re       = mem_en && (cur.op == OP_READ);
  assign mem_addr_sel = mem_en ? {cur.addr[31:4], 4'h0} : 32'h0;
  assign mem_dat      = mem_we ? cur.data : 128'bz;

  // Only legal requests reach ST_ACCESS, so an illegal entry in ST_RESP is the error path.
  always_comb begin
    noc_oup_dat = '0;
    noc_oup_bp  = '0;
    noc_oup_bo  = 1'b0;
    if (state == ST_RESP) begin
      noc_oup_bo = 1'b1;
      for (int i = 0; i < ADDR_BYTES; i++) noc_oup_dat[OFS_ADDR + i] = cur.addr[8*i +: 8];
      if (!req_legal(cur)) begin
        noc_oup_dat[OFS_OP] = OP_ERR;
        noc_oup_bp          = BP_SHORT;
      end else if (cur.op == OP_READ) begin
        noc_oup_dat[OFS_OP] = OP_READ_ACK;
        noc_oup_bp          = BP_LONG;
        for (int i = 0; i < DATA_BYTES; i++) noc_oup_dat[OFS_DATA + i] = rd_data[8*i +: 8];
      end else begin
        noc_oup_dat[OFS_OP] = OP_WRITE_ACK;
        noc_oup_bp          = BP_SHORT;
      end
    end
  end

endmodule

// File: tb/tb_noc_mem_interface.sv
// Randomized bench for noc_mem_interface: transaction-level queueing model plus a behavioural line memory.
module tb_noc_mem_interface;

  localparam int DEPTH = 4;
  localparam int LAT   = 2;
`ifdef ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             fclk = 1'b0;
  logic             rst  = 1'b0;
  logic [31:0][7:0] noc_inp_dat = '0;
  logic [5:0]       noc_inp_bp  = '0;
  logic             noc_inp_bo  = 1'b0;
  logic [31:0][7:0] noc_oup_dat;
  logic [5:0]       noc_oup_bp;
  logic             noc_oup_bo;
  logic             mem_en, mem_we, mem_re;
  logic [31:0]      mem_addr_sel;
  wire  [127:0]     mem_dat;

  noc_mem_interface #(.REQ_FIFO_DEPTH(DEPTH), .MEM_LAT(LAT)) dut (
    .fclk         (fclk),
    .rst          (rst),
    .noc_inp_dat  (noc_inp_dat),
    .noc_inp_bp   (noc_inp_bp),
    .noc_inp_bo   (noc_inp_bo),
    .noc_oup_dat  (noc_oup_dat),
    .noc_oup_bp   (noc_oup_bp),
    .noc_oup_bo   (noc_oup_bo),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
    .mem_addr_sel (mem_addr_sel),
    .mem_dat      (mem_dat)
  );

  always #5 fclk = ~fclk;

  int cyc = 0;
  always @(posedge fclk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Behavioural memory device on the pins.
  logic [127:0] dev_mem [logic [31:0]];
  logic [127:0] dev_rdata = '0;

  function automatic logic [127:0] dflt_line(input logic [31:0] a);
    return {a ^ 32'hA5A5_0000, ~a, a + 32'h1111, a ^ 32'h5A5A_FFFF};
  endfunction

  function automatic logic [127:0] dev_read(input logic [31:0] a);
    if (dev_mem.exists(a)) return dev_mem[a];
    return dflt_line(a);
  endfunction

  assign mem_dat = (mem_en && mem_re) ? dev_rdata : 128'bz;
  always @(negedge fclk) dev_rdata = dev_read(mem_addr_sel);
  always @(posedge fclk) if (mem_en && mem_we) dev_mem[mem_addr_sel] = mem_dat;

  // Reference model: single server fed by a bounded queue, service time per request kind.
  typedef struct {
    int           t;
    logic [5:0]   bp;
    logic [255:0] dat;
  } resp_t;

  typedef struct {
    int           first;
    int           last;
    logic         we;
    logic [31:0]  addr;
    logic [127:0] data;
  } acc_t;

  resp_t        rq[$];
  acc_t         aq[$];
  int           popq[$];
  int           last_pop = -1000;
  int           last_svc = 0;
  logic [127:0] ref_mem [logic [31:0]];

  function automatic void model_req(input int t, input logic [7:0] op, input logic [31:0] addr,
                                    input logic [127:0] data, input logic [5:0] bp);
    int occ;
    int p;
    logic [31:0]  line;
    logic [255:0] r;
    logic [127:0] rd;
    occ = 0;
    foreach (popq[i]) if (popq[i] > t) occ++;
    if (occ >= DEPTH) return;
    p = (t + 1 > last_pop + last_svc) ? t + 1 : last_pop + last_svc;
    popq.push_back(p);
    last_pop = p;
    line = {addr[31:4], 4'h0};
    r = '0;
    r[39:8] = addr;
    if ((op == 8'h01 && bp == 6'd5) || (op == 8'h02 && bp == 6'd21)) begin
      last_svc = LAT + 2;
      aq.push_back('{p, p + LAT - 1, op == 8'h02, line, data});
      if (op == 8'h01) begin
        rd = ref_mem.exists(line) ? ref_mem[line] : dflt_line(line);
        r[7:0] = 8'h81;
        r[167:40] = rd;
        rq.push_back('{p + LAT, 6'd21, r});
      end else begin
        ref_mem[line] = data;
        r[7:0] = 8'h82;
        rq.push_back('{p + LAT, 6'd5, r});
      end
    end else if (ERR_EN) begin
      last_svc = 2;
      r[7:0] = 8'hFF;
      rq.push_back('{p, 6'd5, r});
    end else begin
      last_svc = 1;
    end
  endfunction

  // Output monitor, sampled mid-cycle.
  bit           mon_en = 1'b0;
  int           resp_seen = 0, en_cycles = 0, we_cycles = 0, re_cycles = 0;
  int           last_resp_cyc = 0;
  logic [255:0] last_resp_dat = '0;
  logic [31:0]  last_mem_addr = '0;

  always @(negedge fclk) begin : mon
    int n;
    if (mon_en) begin
      n = cyc;
      while (rq.size() != 0 && rq[0].t < n) void'(rq.pop_front());
      if (rq.size() != 0 && rq[0].t == n) begin
        chk("rsp_bo", noc_oup_bo, 1'b1);
        chk("rsp_bp", noc_oup_bp, rq[0].bp);
        chk("rsp_dat", noc_oup_dat, rq[0].dat);
        void'(rq.pop_front());
      end else begin
        chk("idle_bo", noc_oup_bo, 1'b0);
        chk("idle_bp", noc_oup_bp, 6'd0);
        chk("idle_dat", noc_oup_dat, 256'd0);
      end
      while (aq.size() != 0 && aq[0].last < n) void'(aq.pop_front());
      if (aq.size() != 0 && aq[0].first <= n) begin
        chk("acc_en", mem_en, 1'b1);
        chk("acc_we", mem_we, aq[0].we);
        chk("acc_re", mem_re, !aq[0].we);
        chk("acc_addr", mem_addr_sel, aq[0].addr);
        if (aq[0].we) chk("acc_wdat", mem_dat, aq[0].data);
        if (aq[0].last == n) void'(aq.pop_front());
      end else begin
        chk("noacc_en", mem_en, 1'b0);
        chk("noacc_we", mem_we, 1'b0);
        chk("noacc_re", mem_re, 1'b0);
      end
      chk("we_re_excl", mem_we && mem_re, 1'b0);
      if (noc_oup_bo) begin
        resp_seen++;
        last_resp_cyc = n;
        last_resp_dat = noc_oup_dat;
      end
      if (mem_en) en_cycles++;
      if (mem_we) we_cycles++;
      if (mem_re) begin
        re_cycles++;
        last_mem_addr = mem_addr_sel;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge fclk);
    #1;
  endtask

  task automatic send(input logic [7:0] op, input logic [31:0] addr, input logic [127:0] data,
                      input logic [5:0] bp);
    for (int i = 0; i < 32; i++) noc_inp_dat[i] = 8'($urandom);
    noc_inp_dat[0] = op;
    for (int i = 0; i < 4; i++)  noc_inp_dat[1 + i] = addr[8*i +: 8];
    for (int i = 0; i < 16; i++) noc_inp_dat[5 + i] = data[8*i +: 8];
    noc_inp_bp = bp;
    noc_inp_bo = 1'b1;
    if (rst) model_req(cyc + 1, op, addr, data, bp);
    @(posedge fclk);
    #1;
    noc_inp_bo = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((rq.size() != 0 || aq.size() != 0 || last_pop >= cyc) && guard < 400) begin
      idle(1);
      guard++;
    end
    chk("drain_timeout", guard >= 400, 1'b0);
    idle(3);
  endtask

  task automatic pulse_reset();
    int    k;
    acc_t  a;
    resp_t rkeep[$];
    acc_t  akeep[$];
    k = cyc;
    rst = 1'b0;
    foreach (rq[i]) if (rq[i].t <= k) rkeep.push_back(rq[i]);
    foreach (aq[i]) begin
      if (aq[i].first <= k) begin
        a = aq[i];
        if (a.last > k) a.last = k;
        akeep.push_back(a);
      end
    end
    rq = rkeep;
    aq = akeep;
    popq.delete();
    last_pop = -1000;
    last_svc = 0;
    idle(1);
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int           t0, r0, e0, w0, q0;
    logic [127:0] wd;
    logic [7:0]   op;
    logic [5:0]   bp;
    logic [31:0]  addr;

    idle(3);
    chk("rst_en", mem_en, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_re", mem_re, 1'b0);
    chk("rst_bo", noc_oup_bo, 1'b0);
    chk("rst_bp", noc_oup_bp, 6'd0);
    chk("rst_dat", noc_oup_dat, 256'd0);
    rst = 1'b1;
    idle(1);
    mon_en = 1'b1;
    idle(2);

    // WRITE then READ of the same line
    for (int i = 0; i < 16; i++) wd[8*i +: 8] = 8'(i);
    t0 = cyc + 1;
    send(8'h02, 32'h0000_0100, wd, 6'd21);
    idle(5);
    chk("wr_ack_lat", last_resp_cyc - t0, LAT + 1);
    chk("wr_ack_op", last_resp_dat[7:0], 8'h82);
    drain();
    send(8'h01, 32'h0000_0100, '0, 6'd5);
    drain();
    chk("rd_ack_op", last_resp_dat[7:0], 8'h81);
    chk("rd_ack_data", last_resp_dat[167:40], 128'h0F0E0D0C_0B0A0908_07060504_03020100);

    // READ with unaligned address
    r0 = re_cycles;
    send(8'h01, 32'h1234_5678, '0, 6'd5);
    drain();
    chk("rd_re_cycles", re_cycles - r0, LAT);
    chk("rd_line_addr", last_mem_addr, 32'h1234_5670);
    chk("rd_echo_addr", last_resp_dat[39:8], 32'h1234_5678);

    // Two requests keep the FSM busy, then five back-to-back: fifth is dropped
    q0 = resp_seen;
    send(8'h01, 32'h0000_0200, '0, 6'd5);
    send(8'h01, 32'h0000_0210, '0, 6'd5);
    for (int i = 0; i < 5; i++) send(8'h02, 32'h0000_0300 + 32'(i * 16), {4{32'($urandom)}}, 6'd21);
    drain();
    chk("burst_resp_cnt", resp_seen - q0, 6);

    // Illegal opcode
    q0 = resp_seen;
    e0 = en_cycles;
    send(8'h07, 32'hDEAD_BEEF, '0, 6'd5);
    drain();
    chk("badop_resp_cnt", resp_seen - q0, ERR_EN ? 1 : 0);
    chk("badop_no_en", en_cycles - e0, 0);

    // WRITE with wrong byte count
    w0 = we_cycles;
    send(8'h02, 32'h0000_0400, {4{32'hCAFE_F00D}}, 6'd20);
    drain();
    chk("badbp_no_we", we_cycles - w0, 0);

    // Randomized traffic over a small set of lines
    for (int it = 0; it < 250; it++) begin
      addr = 32'h0000_2000 + 32'($urandom_range(0, 7) << 4) + 32'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 2))
          0:       begin op = 8'($urandom_range(3, 255)); bp = 6'd5;  end
          1:       begin op = 8'h01;                      bp = 6'd21; end
          default: begin op = 8'h02;                      bp = 6'd5;  end
        endcase
      end else if ($urandom_range(0, 1) == 0) begin
        op = 8'h01; bp = 6'd5;
      end else begin
        op = 8'h02; bp = 6'd21;
      end
      send(op, addr, {$urandom, $urandom, $urandom, $urandom}, bp);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 6));
    end
    drain();

    // Reset during the second ACCESS cycle of a WRITE aborts it silently
    q0 = resp_seen;
    send(8'h02, 32'h0000_9000, {4{32'h1357_9BDF}}, 6'd21);
    idle(2);
    pulse_reset();
    chk("abort_en", mem_en, 1'b0);
    chk("abort_we", mem_we, 1'b0);
    chk("abort_re", mem_re, 1'b0);
    chk("abort_bo", noc_oup_bo, 1'b0);
    idle(6);
    chk("abort_no_resp", resp_seen - q0, 0);
    send(8'h01, 32'h0000_0100, '0, 6'd5);
    drain();
    chk("post_rst_rd", last_resp_dat[167:40], 128'h0F0E0D0C_0B0A0908_07060504_03020100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/noc_mem_interface.md
Name: noc_mem_interface

Overview:
Bridges the core's NoC packet bus to an external 128-bit, 16-byte-line memory.
- Accepts read/write request packets from the core.
- Performs a fixed-latency access on the shared tri-state memory data bus.
- Returns one response packet per request.
- Single clock domain; the memory pins are driven from the same clock.

Parameters:
- REQ_FIFO_DEPTH, 4, number of queued request packets (power of two, ≥2).
- MEM_LAT, 2, cycles each memory access holds mem_en asserted (≥1).

Ports:
- fclk  in  1  fabric clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low.
- noc_inp_dat  in  32x8  request packet bytes from core.
- noc_inp_bp  in  6  count of valid bytes in noc_inp_dat.
- noc_inp_bo  in  1  request valid strobe, one cycle per packet.
- noc_oup_dat  out  32x8  response packet bytes.
- noc_oup_bp  out  6  response valid byte count.
- noc_oup_bo  out  1  response valid strobe, one cycle.
- mem_en  out  1  memory access enable.
- mem_we  out  1  write strobe.
- mem_re  out  1  read strobe.
- mem_addr_sel  out  32  line address.
- mem_dat  inout  128  memory data; driven only during writes, else high-Z.

Behaviour:
- Packet format: byte0 opcode; bytes1-4 address, little-endian; bytes5-20 data, byte5 = mem_dat[7:0].
- Request opcodes: 0x01 READ (bp must be 5), 0x02 WRITE (bp must be 21). Unused bytes are don't-care.
- Response opcodes: 0x81 READ_ACK, bp=21, bytes1-4 echo address, bytes5-20 read data. 0x82 WRITE_ACK, bp=5, bytes1-4 echo address. Unused response bytes are 0.
- Capture: at every edge with noc_inp_bo=1, push {opcode, addr, data, bp} into the request FIFO.
- FIFO full: a request arriving while full is dropped. A push and pop in the same cycle while full is accepted.
- Address: mem_addr_sel = addr with bits[3:0] forced to 0. The echoed address is the unmodified request address.
- FSM states IDLE, ACCESS, RESP.
- IDLE: if the FIFO is non-empty, pop the head.
  - Legal request: go to ACCESS.
  - Illegal opcode or bp mismatch: handled per the optional feature.
- ACCESS: mem_en=1 for exactly MEM_LAT cycles.
  - WRITE: mem_we=1 and mem_dat driven with the data.
  - READ: mem_re=1 and mem_dat is high-Z; mem_dat is sampled on the final ACCESS edge.
  - Then go to RESP.
- RESP: noc_oup_bo=1 for one cycle with the response, then IDLE. In all other cycles noc_oup_bo=0, and dat/bp hold 0.
- Latency, bo sampled at edge T with the FIFO empty and FSM idle: ACCESS cycles T+1..T+MEM_LAT, response valid in cycle T+MEM_LAT+1. Back-to-back requests occupy MEM_LAT+2 cycles each.
- mem_we and mem_re are never both 1. Strobes are 0 outside ACCESS.
- No backpressure on the response bus: the core always accepts.
- Reset, rst=0 at an edge:
  - FIFO emptied, FSM to IDLE.
  - All outputs 0, mem_dat released to high-Z.
  - An in-flight access is aborted with no response. A request presented during reset is dropped.

Optional Feature:
ERR_RESP_EN.
- Defined: an illegal request produces an error response with no memory access: opcode 0xFF, bp=5, bytes1-4 echo address, sent via the RESP state in the cycle after the pop.
- Undefined: an illegal request is popped and silently discarded; the FSM stays IDLE.

Decomposition:
- Package noc_mem_pkg holds:
  - opcode constants (0x01, 0x02, 0x81, 0x82, 0xFF);
  - byte offsets and expected bp values (5, 21);
  - the FSM state enum;
  - the packed request-entry typedef.
- One sub-module, noc_mem_req_fifo: synchronous FIFO with push, pop, full and empty, parameterised by depth and entry type.

Test Plan:
- WRITE addr 0x00000100, data bytes 0x00..0x0F, then READ 0x00000100 with the memory model echoing stored data -> WRITE_ACK bp=5 at T+3; READ_ACK bp=21 with bytes5-20 = 0x00..0x0F.
- READ addr 0x1234_5678 -> mem_addr_sel=0x1234_5670 and mem_re=1 for 2 cycles; response echoes 0x1234_5678.
- Five requests on consecutive cycles with REQ_FIFO_DEPTH=4, FSM busy -> four responses in order; the fifth is dropped.
- Opcode 0x07 with bp=5 -> 0xFF error response if ERR_RESP_EN, else no response and no mem_en.
- rst=0 during the second ACCESS cycle of a WRITE -> all strobes 0 the next cycle, mem_dat high-Z, no response.
- WRITE with bp=20 -> treated as illegal; no mem_we.
